// File: rtl/dac_sample_feeder.sv
// Sample-rate front end for the delta-sigma DAC: buffers PCM samples, releases one per
// sample period and linearly interpolates between them, driving an offset-binary code.
module dac_sample_feeder #(
    parameter int MSBI      = 7,
    parameter int RATE_LOG2 = 6,
    parameter int FIFO_AW   = 3
) (
    input  logic             CLK_i,
    input  logic             RSTn_i,
    input  logic [MSBI:0]    S_DATA_i,
    input  logic             S_VALID_i,
    output logic             S_READY_o,
    input  logic             EN_i,
    input  logic             CLR_UNDERRUN_i,
    output logic [MSBI:0]    DACin_o,
    output logic             TICK_o,
    output logic             UNDERRUN_o,
    output logic [FIFO_AW:0] LEVEL_o
);

    localparam int DW    = MSBI + 1;
    localparam int DLW   = MSBI + 2;
    localparam int ACCW  = MSBI + RATE_LOG2 + 2;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [RATE_LOG2-1:0] CNT_LAST = '1;

    logic [DW-1:0]            mem_q [DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]         level_q, level_d;
    logic [RATE_LOG2-1:0]     cnt_q, cnt_d;
    logic signed [DW-1:0]     nxt_q, nxt_d;
    logic signed [DLW-1:0]    delta_q, delta_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic                     tick_q, tick_d;
    logic                     underrun_q, underrun_d;

    logic                     push, pop, tick, fifo_empty;
    logic [DW-1:0]            head;
    logic [DW-1:0]            code;

    always_comb begin
        fifo_empty = (level_q == '0);
        S_READY_o  = (level_q != FULL_LEVEL);
        push       = S_VALID_i && S_READY_o;
        tick       = EN_i && (cnt_q == CNT_LAST);
        pop        = tick && !fifo_empty;
        head       = mem_q[rd_ptr_q];

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        nxt_d      = nxt_q;
        delta_d    = delta_q;
        acc_d      = acc_q;
        underrun_d = underrun_q;
        tick_d     = tick;

        if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
            default: level_d = level_q;
        endcase

        if (EN_i) cnt_d = cnt_q + RATE_LOG2'(1);

        if (CLR_UNDERRUN_i) underrun_d = 1'b0;

        // Each period restarts from the old target so the ramp lands on it exactly.
        if (tick) begin
            acc_d = {{(ACCW-DW){nxt_q[MSBI]}}, nxt_q} <<< RATE_LOG2;
            if (pop) begin
                nxt_d   = head;
                delta_d = {head[MSBI], head} - {nxt_q[MSBI], nxt_q};
            end else begin
                delta_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (EN_i) begin
            acc_d = acc_q + {{(ACCW-DLW){delta_q[DLW-1]}}, delta_q};
        end

        code       = acc_q[RATE_LOG2 +: DW];
        DACin_o    = {~code[MSBI], code[MSBI-1:0]};
        TICK_o     = tick_q;
        UNDERRUN_o = underrun_q;
        LEVEL_o    = level_q;
    end

    // NOTE: the sample storage has no reset; the pointers and level alone define validity.
    always_ff @(posedge CLK_i) begin
        if (push) mem_q[wr_ptr_q] <= S_DATA_i;
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            nxt_q      <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            nxt_q      <= nxt_d;
            delta_q    <= delta_d;
            acc_q      <= acc_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboarded bench for dac_sample_feeder: an abstract ramp model predicts every cycle's
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_dac_sample_feeder;

    localparam int MSBI      = 7;
    localparam int RATE_LOG2 = 2;
    localparam int FIFO_AW   = 2;
    localparam int N         = 1 << RATE_LOG2;
    localparam int DEPTH     = 1 << FIFO_AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [MSBI:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [MSBI:0]    dac;
    logic             tick_o;
    logic             underrun;
    logic [FIFO_AW:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    dac_sample_feeder #(.MSBI(MSBI), .RATE_LOG2(RATE_LOG2), .FIFO_AW(FIFO_AW)) dut (
        .CLK_i          (clk),
        .RSTn_i         (rst_n),
        .S_DATA_i       (s_data),
        .S_VALID_i      (s_valid),
        .S_READY_o      (s_ready),
        .EN_i           (en),
        .CLR_UNDERRUN_i (clr),
        .DACin_o        (dac),
        .TICK_o         (tick_o),
        .UNDERRUN_o     (underrun),
        .LEVEL_o        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int dac;
        int tick;
        int und;
        int level;
        int ready;
    } exp_t;

    exp_t exp_q[$];
    int   mq[$];
    int   m_cnt, m_start, m_target, m_k, m_tick, m_und;

    function automatic int floor_div(input int num, input int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   code;
        code    = m_start + floor_div((m_target - m_start) * m_k, N);
        e.dac   = (code + 128) & 255;
        e.tick  = m_tick;
        e.und   = m_und;
        e.level = mq.size();
        e.ready = (mq.size() < DEPTH) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit can_push;
        bit do_tick;
        bit und_set;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0; m_start = 0; m_target = 0; m_k = 0; m_tick = 0; m_und = 0;
            exp_q.delete();
            exp_q.push_back(model_out());
        end else begin
            can_push = (mq.size() < DEPTH);
            do_tick  = en && (m_cnt == N - 1);
            und_set  = 1'b0;
            if (do_tick) begin
                m_start = m_target;
                m_k     = 0;
                if (mq.size() > 0) m_target = mq.pop_front();
                else               und_set = 1'b1;
            end else if (en) begin
                m_k++;
            end
            if (s_valid && can_push) mq.push_back(int'($signed(s_data)));
            if (und_set)  m_und = 1;
            else if (clr) m_und = 0;
            m_tick = do_tick ? 1 : 0;
            if (en) m_cnt = (m_cnt + 1) % N;
            exp_q.push_back(model_out());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dac",      int'(dac),      e.dac);
            check("tick",     int'(tick_o),   e.tick);
            check("underrun", int'(underrun), e.und);
            check("level",    int'(level),    e.level);
            check("ready",    int'(s_ready),  e.ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [MSBI:0] d);
        bit taken;
        taken   = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 64 && !taken; i++) begin
            taken = s_ready;
            step();
        end
        s_valid = 1'b0;
        if (!taken) check("push_timeout", 0, 1);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            seen = tick_o;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic collect_codes(input int cycles, output int seq[$]);
        seq.delete();
        for (int i = 0; i < cycles; i++) begin
            if (seq.size() == 0 || seq[$] != int'(dac)) seq.push_back(int'(dac));
            step();
        end
    endtask

    task automatic check_seq(input string name, input int seq[$], input int want[$]);
        check({name, "_len"}, seq.size(), want.size());
        for (int i = 0; i < want.size() && i < seq.size(); i++)
            check(name, seq[i], want[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int want[$];
        int ticks;
        int gap;
        bit seen;

        // Reset state
        #1 rst_n = 1'b0;
        step();
        step();
        check("rst_dac",   int'(dac),      'h80);
        check("rst_ready", int'(s_ready),  1);
        check("rst_level", int'(level),    0);
        check("rst_und",   int'(underrun), 0);
        rst_n = 1'b1;

        // Ramp up from midscale to 0x40, then hold with underrun
        en = 1'b1;
        push_sample(8'h40);
        collect_codes(16, seq);
        want = '{'h80, 'h90, 'hA0, 'hB0, 'hC0};
        check_seq("ramp_up", seq, want);
        check("hold_und", int'(underrun), 1);

        // Ramp down 0x40 -> -64
        push_sample(8'hC0);
        collect_codes(16, seq);
        want = '{'hC0, 'hA0, 'h80, 'h60, 'h40};
        check_seq("ramp_down", seq, want);

        // Fill with EN low: the fifth sample is held until a pop
        en = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = (i < 4) ? 8'(8'h10 * (i + 1)) : 8'h55;
            step();
        end
        check("full_level", int'(level),   DEPTH);
        check("full_ready", int'(s_ready), 0);
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            seen = s_ready;
            step();
        end
        s_valid = 1'b0;
        if (!seen) check("held_push_timeout", 0, 1);
        for (int i = 0; i < 6 * N; i++) step();

        // EN low mid-ramp: everything frozen, then tick spacing of N enabled cycles
        push_sample(8'h20);
        wait_tick();
        step();
        step();
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ticks += int'(tick_o);
        end
        check("frozen_ticks", ticks, 0);
        en = 1'b1;
        wait_tick();
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            gap++;
            seen = tick_o;
        end
        check("tick_spacing", gap, N);

        // Reset mid-ramp
        push_sample(8'h60);
        push_sample(8'h90);
        wait_tick();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_dac",   int'(dac),      'h80);
        check("midrst_level", int'(level),    0);
        check("midrst_und",   int'(underrun), 0);
        check("midrst_ready", int'(s_ready),  1);
        step();
        rst_n = 1'b1;

        // Underrun set wins over a simultaneous clear
        en  = 1'b1;
        clr = 1'b1;
        wait_tick();
        check("set_over_clr", int'(underrun), 1);
        step();
        check("clr_after", int'(underrun), 0);
        clr = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            en      = ($urandom_range(0, 9) < 8);
            clr     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        s_valid = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
